// File: rtl/layer_seq_pkg.sv
// rtl/layer_seq_pkg.sv - shared types and sizing helpers for the layer sequencer
package layer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } seq_state_e;

  localparam int NUM_BANKS = 2;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_seq_capture.sv
// rtl/layer_seq_capture.sv - gathers per-neuron valid pulses into one complete frame
module layer_seq_capture
  import layer_seq_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int DATAWIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_NEURONS*DATAWIDTH-1:0] x_in,
  input  logic [NUM_NEURONS-1:0]         x_valid,
  output logic                           frame_complete,
  output logic [NUM_NEURONS*DATAWIDTH-1:0] frame_data,
  output logic                           dup_err
);

  logic [NUM_NEURONS-1:0]           sticky_q, sticky_d;
  logic [NUM_NEURONS*DATAWIDTH-1:0] collect_q, collect_d;
  logic [NUM_NEURONS-1:0]           new_bits;

  assign new_bits       = x_valid & ~sticky_q;
  assign dup_err        = |(x_valid & sticky_q);
  assign frame_complete = &(sticky_q | x_valid);
  // Words arriving in the completing cycle bypass the collect register.
  assign frame_data     = collect_d;

  always_comb begin
    collect_d = collect_q;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (new_bits[i]) collect_d[i*DATAWIDTH +: DATAWIDTH] = x_in[i*DATAWIDTH +: DATAWIDTH];
    end
    sticky_d = frame_complete ? '0 : (sticky_q | x_valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q  <= '0;
      collect_q <= '0;
    end else begin
      sticky_q  <= sticky_d;
      collect_q <= collect_d;
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - double-buffered parallel-to-serial bridge between NN layers
// Optional running argmax over each streamed frame: LAYER_SEQ_ARGMAX_EN.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int DATAWIDTH   = 16,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_NEURONS*DATAWIDTH-1:0] x_in,
  input  logic [NUM_NEURONS-1:0]           x_valid,
  output logic [DATAWIDTH-1:0]             out_val,
  output logic                             out_valid,
  output logic                             frame_done,
  output logic                             busy,
  output logic                             overflow,
  output logic [$clog2(NUM_NEURONS)-1:0]   argmax_idx,
  output logic                             argmax_vld
);

  localparam int IW = $clog2(NUM_NEURONS);
  localparam int GW = cnt_w(GAP_CYCLES + 1);
  localparam int FW = NUM_NEURONS * DATAWIDTH;

  seq_state_e           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [FW-1:0]        bank_q [NUM_BANKS];
  logic [FW-1:0]        bank_d [NUM_BANKS];
  logic [NUM_BANKS-1:0] full_q, full_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;

  logic                 frame_complete;
  logic [FW-1:0]        frame_data;
  logic                 dup_err;
  logic                 emit;
  logic                 last;
  logic [FW-1:0]        rd_bank;

  layer_seq_capture #(
    .NUM_NEURONS (NUM_NEURONS),
    .DATAWIDTH   (DATAWIDTH)
  ) u_capture (
    .clk            (clk),
    .rst            (rst),
    .x_in           (x_in),
    .x_valid        (x_valid),
    .frame_complete (frame_complete),
    .frame_data     (frame_data),
    .dup_err        (dup_err)
  );

  // IDLE emits word 0 directly so a fresh bank streams the cycle after capture.
  assign emit       = (state_q == STREAM) || ((state_q == IDLE) && full_q[rd_ptr_q]);
  assign last       = emit && (idx_q == IW'(NUM_NEURONS - 1));
  assign rd_bank    = bank_q[rd_ptr_q];
  assign out_val    = emit ? rd_bank[idx_q*DATAWIDTH +: DATAWIDTH] : '0;
  assign out_valid  = emit;
  assign frame_done = last;
  assign busy       = (|full_q) || (state_q != IDLE);
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    bank_d     = bank_q;
    full_d     = full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | dup_err;

    case (state_q)
      IDLE, STREAM: begin
        if (emit) begin
          gap_d = '0;
          if (last) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
            idx_d            = '0;
            if (full_q[~rd_ptr_q]) state_d = (GAP_CYCLES > 0) ? GAP : STREAM;
            else                   state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = (GAP_CYCLES > 0) ? GAP : STREAM;
          end
        end
      end
      GAP: begin
        if (int'(gap_q) >= GAP_CYCLES - 1) begin
          state_d = STREAM;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture sees the bank flags after this cycle's release.
    if (frame_complete) begin
      if (full_d[wr_ptr_q]) begin
        overflow_d = 1'b1;
      end else begin
        bank_d[wr_ptr_q] = frame_data;
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      for (int b = 0; b < NUM_BANKS; b++) bank_q[b] <= '0;
      full_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      bank_q     <= bank_d;
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef LAYER_SEQ_ARGMAX_EN
  logic signed [DATAWIDTH-1:0] best_q, best_d;
  logic [IW-1:0]               best_idx_q, best_idx_d;
  logic [IW-1:0]               am_idx_q, am_idx_d;
  logic                        am_vld_q, am_vld_d;
  logic                        take;

  // Strict compare keeps the lower index on ties.
  assign take = (idx_q == '0) || ($signed(out_val) > best_q);

  always_comb begin
    best_d     = best_q;
    best_idx_d = best_idx_q;
    am_idx_d   = am_idx_q;
    am_vld_d   = 1'b0;
    if (emit) begin
      if (take) begin
        best_d     = $signed(out_val);
        best_idx_d = idx_q;
      end
      if (last) begin
        am_idx_d = take ? idx_q : best_idx_q;
        am_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_q     <= '0;
      best_idx_q <= '0;
      am_idx_q   <= '0;
      am_vld_q   <= 1'b0;
    end else begin
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      am_idx_q   <= am_idx_d;
      am_vld_q   <= am_vld_d;
    end
  end

  assign argmax_idx = am_idx_q;
  assign argmax_vld = am_vld_q;
`else
  assign argmax_idx = '0;
  assign argmax_vld = 1'b0;
`endif

endmodule
